logic_result_wb: RTL and testbench

LOGIC_RESULT_WB -- requirements
Module: logic_result_wb

---
 rtl/logic_result_wb_pkg.sv | 33 +++
 rtl/logic_result_wb_result_fifo.sv | 78 +++++++
 rtl/logic_result_wb.sv | 85 ++++++++
 tb/tb_logic_result_wb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_result_wb_pkg.sv
// rtl/logic_result_wb_pkg.sv - shared ALU package: default widths, entry record, occupancy states
//
// Purpose: common definitions for the logic-unit result write-back path.
//   ALU_DATA_W / ALU_ADDR_W : default result width and register-index width
//   wb_entry_t              : {dest, data} record held in each queue entry
//   OCC_*                   : occupancy states of the write-back queue
//   occ_of()                : maps an entry count to its occupancy state
package logic_result_wb_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_ADDR_W = 3;

  typedef struct packed {
    logic [ALU_ADDR_W-1:0] dest;
    logic [ALU_DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_PARTIAL = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;

  // Occupancy depends on the count alone, never on the operation that produced it.
  function automatic logic [1:0] occ_of(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) begin
      return OCC_EMPTY;
    end else if (cnt >= depth) begin
      return OCC_FULL;
    end else begin
      return OCC_PARTIAL;
    end
  endfunction

endpackage

// File: rtl/logic_result_wb_result_fifo.sv
// rtl/logic_result_wb_result_fifo.sv - result queue storage and pointers
//
// Purpose: circular buffer of DEPTH entries, WIDTH bits each.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (pointers and count only)
//   push_i   : write wdata_i at the write pointer (caller guarantees not full)
//   wdata_i  : entry to store
//   pop_i    : advance the read pointer (caller guarantees not empty)
//   rdata_o  : head entry, read combinationally from registered state
//   count_o  : number of occupied entries
module result_fifo
  import logic_result_wb_pkg::*;
#(
  parameter int WIDTH = ALU_ADDR_W + ALU_DATA_W,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Explicit wrap keeps the pointer correct even if the last index is not all-ones.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; reset only discards entries via the pointers.
  always_ff @(posedge clk) begin
    if (push_i && !rst) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/logic_result_wb.sv
// rtl/logic_result_wb.sv - logic-unit result write-back queue with handshake and flags
//
// Purpose: buffers logic-unit results and presents them to the register file in order.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   res_valid/res_ready : producer handshake; push when both are 1
//   res_data, res_dest  : result word and destination register index
//   wb_en/wb_ack        : register-file handshake; pop when both are 1
//   wb_addr, wb_data    : head entry destination and data
//   wb_zero, wb_parity  : head data is all zeros / XOR-reduction of head data
//   count               : number of occupied entries
// DEPTH must be a power of two in 2..16.
module logic_result_wb
  import logic_result_wb_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ALU_ADDR_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic [ADDR_W-1:0] res_dest,
  output logic              res_ready,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              wb_parity,
  input  logic              wb_ack,
  output logic [CNT_W-1:0]  count
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_d;
  logic [1:0]         occ_q, occ_d;
  logic               push;
  logic               pop;

  // Handshake flags come from the registered occupancy state, so a pop in the
  // same cycle never opens a slot for a push while full.
  assign res_ready = (occ_q != OCC_FULL);
  assign wb_en     = (occ_q != OCC_EMPTY);

  assign push = res_valid && res_ready;
  assign pop  = wb_en && wb_ack;

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({res_dest, res_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  always_comb begin
    count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);
    occ_d   = occ_of(int'(count_d), DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign wb_addr   = head[ENTRY_W-1:DATA_W];
  assign wb_data   = head[DATA_W-1:0];
  assign wb_zero   = (wb_data == '0);
  assign wb_parity = ^wb_data;
  assign count     = fifo_count;

endmodule

// File: tb/tb_logic_result_wb.sv
// tb/tb_logic_result_wb.sv - scoreboard testbench for logic_result_wb
module tb_logic_result_wb;
  import logic_result_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  res_dest;
  logic        res_ready;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_zero;
  logic        wb_parity;
  logic        wb_ack;
  logic [2:0]  count;

  always #5 clk = ~clk;

  logic_result_wb #(
    .DATA_W (16),
    .DEPTH  (4),
    .ADDR_W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_dest  (res_dest),
    .res_ready (res_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_zero   (wb_zero),
    .wb_parity (wb_parity),
    .wb_ack    (wb_ack),
    .count     (count)
  );

  typedef struct packed {
    wb_entry_t e;
    logic      zero;
    logic      parity;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one result, expects it to be accepted, and records the expected write-back.
  task automatic push(input logic [2:0] d, input logic [15:0] v, input logic z, input logic p);
    exp_t x;
    res_valid = 1'b1;
    res_dest  = d;
    res_data  = v;
    check("res_ready_at_push", res_ready, 1);
    x.e.dest = d;
    x.e.data = v;
    x.zero   = z;
    x.parity = p;
    sb.push_back(x);
    tick();
    res_valid = 1'b0;
  endtask

  // Monitor: every presented write-back must match the scoreboard head; entries leave on ack.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && wb_en) begin
        if (sb.size() == 0) begin
          check("wb_en_with_nothing_expected", wb_en, 0);
        end else begin
          x = sb[0];
          check("wb_addr", wb_addr, x.e.dest);
          check("wb_data", wb_data, x.e.data);
          check("wb_zero", wb_zero, x.zero);
          check("wb_parity", wb_parity, x.parity);
          if (wb_ack) begin
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fill_data [4] = '{16'hFFFF, 16'h0000, 16'hF00F, 16'h0001};
    logic        fill_zero [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        fill_par  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;
    res_dest  = '0;
    wb_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_wb_en", wb_en, 0);
    check("reset_res_ready", res_ready, 1);
    check("reset_count", count, 0);

    // Single push with the register file always ready.
    wb_ack = 1'b1;
    push(3'd2, 16'h0006, 1'b0, 1'b0);
    check("single_count_after_push", count, 1);
    check("single_wb_en", wb_en, 1);
    tick();
    check("single_count_after_pop", count, 0);
    wb_ack = 1'b0;

    // Fill to full, refused fifth push, then drain.
    for (int i = 0; i < 4; i++) begin
      push(3'(i), fill_data[i], fill_zero[i], fill_par[i]);
    end
    check("full_count", count, 4);
    check("full_res_ready", res_ready, 0);
    res_valid = 1'b1;
    res_dest  = 3'd4;
    res_data  = 16'h1234;
    tick();
    res_valid = 1'b0;
    check("full_refused_count", count, 4);
    wb_ack = 1'b1;
    repeat (4) tick();
    check("drain_count", count, 0);
    check("drain_wb_en", wb_en, 0);
    wb_ack = 1'b0;

    // Simultaneous push and pop at count 2.
    push(3'd1, 16'h0A0A, 1'b0, 1'b0);
    push(3'd2, 16'h0C00, 1'b0, 1'b0);
    check("pp_count_before", count, 2);
    wb_ack = 1'b1;
    push(3'd3, 16'h0007, 1'b0, 1'b1);
    wb_ack = 1'b0;
    check("pp_count_after", count, 2);
    wb_ack = 1'b1;
    repeat (2) tick();
    check("pp_drain_count", count, 0);

    // Ten back-to-back push/pop pairs carry both pointers around the ring.
    for (int i = 0; i < 10; i++) begin
      push(3'(i), 16'(i), (i == 0), ^(16'(i)));
    end
    tick();
    check("wrap_drain_count", count, 0);
    wb_ack = 1'b0;

    // Stall: head must hold while the register file withholds ack.
    push(3'd6, 16'h8001, 1'b0, 1'b0);
    push(3'd4, 16'h0100, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_count", count, 2);
      check("stall_wb_addr", wb_addr, 3'd6);
      check("stall_wb_data", wb_data, 16'h8001);
    end
    wb_ack = 1'b1;
    repeat (2) tick();
    check("stall_drain_count", count, 0);
    wb_ack = 1'b0;

    // Reset with three entries queued, and a push offered in the reset cycle.
    push(3'd1, 16'h1111, 1'b0, 1'b0);
    push(3'd2, 16'h2222, 1'b0, 1'b0);
    push(3'd3, 16'h3333, 1'b0, 1'b0);
    check("prereset_count", count, 3);
    rst       = 1'b1;
    res_valid = 1'b1;
    res_dest  = 3'd7;
    res_data  = 16'h5555;
    sb.delete();
    tick();
    rst       = 1'b0;
    res_valid = 1'b0;
    check("midreset_wb_en", wb_en, 0);
    check("midreset_count", count, 0);
    check("midreset_res_ready", res_ready, 1);
    wb_ack = 1'b1;
    push(3'd5, 16'h00AA, 1'b0, 1'b0);
    tick();
    check("postreset_drain_count", count, 0);
    wb_ack = 1'b0;

    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
